// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch with pipelined imem requests and a prefetch FIFO.
// Optional misaligned-redirect trap entry: define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clkin,
  input  logic            nrst_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  output logic            instr_valid_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc_out,
  output logic            instr_misalign_out,
  input  logic            instr_ready_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic            run_q, run_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] push_pc_q, push_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;

  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic            credit;
  logic            gnt_acc;
  logic            valid;
  logic            pop;
  logic            push;
  logic            halt;
  logic [XLEN-1:0] tgt;

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_instr;
  logic [XLEN-1:0] wr_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic             halt_q, halt_d;
  logic             trap;
  logic             wr_mis;
  logic [DEPTH-1:0] mis_mem_q;

  always_comb begin
    tgt  = redirect_pc_in;
    trap = |redirect_pc_in[1:0];
  end

  assign halt = halt_q;
`else
  always_comb begin
    tgt = redirect_pc_in & ~XLEN'(3);
  end

  assign halt = 1'b0;
`endif

  always_comb begin
    credit = ({1'b0, inflight_q} + {1'b0, count_q}) < LIMIT;
    imem_req_out = run_q && !halt && credit;
    gnt_acc = imem_req_out && imem_gnt_in;
    valid = count_q != '0;
    pop = valid && instr_ready_in && !redirect_in;
    push = imem_rvalid_in && (discard_q == '0) && !redirect_in;

    run_d = 1'b1;
    fetch_pc_d = gnt_acc ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    push_pc_d = push ? push_pc_q + XLEN'(4) : push_pc_q;
    inflight_d = inflight_q + CW'(gnt_acc) - CW'(imem_rvalid_in);
    discard_d = discard_q;
    if (imem_rvalid_in && discard_q != '0) begin
      discard_d = discard_q - CW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);

    wr_en = push;
    wr_idx = wptr_q;
    wr_instr = imem_rdata_in;
    wr_pc = push_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_d = halt_q;
    wr_mis = 1'b0;
`endif

    // Everything still outstanding after this edge is stale.
    if (redirect_in) begin
      fetch_pc_d = tgt;
      push_pc_d = tgt;
      discard_d = inflight_d;
      count_d = '0;
      wptr_d = '0;
      rptr_d = '0;
      wr_en = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_d = trap;
      if (trap) begin
        wr_en = 1'b1;
        wr_idx = '0;
        wr_instr = NOP;
        wr_pc = tgt;
        wr_mis = 1'b1;
        wptr_d = AW'(1);
        count_d = CW'(1);
      end
`endif
    end
  end

  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      run_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      push_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q <= '0;
      count_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      run_q <= run_d;
      fetch_pc_q <= fetch_pc_d;
      push_pc_q <= push_pc_d;
      inflight_q <= inflight_d;
      discard_q <= discard_d;
      count_q <= count_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      instr_mem_q[wr_idx] <= wr_instr;
      pc_mem_q[wr_idx] <= wr_pc;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      halt_q <= 1'b0;
      mis_mem_q <= '0;
    end else begin
      halt_q <= halt_d;
      if (wr_en) begin
        mis_mem_q[wr_idx] <= wr_mis;
      end
    end
  end

  assign instr_misalign_out = valid && mis_mem_q[rptr_q];
`else
  assign instr_misalign_out = 1'b0;
`endif

  always_comb begin
    imem_addr_out = fetch_pc_q;
    instr_valid_out = valid;
    instr_out = valid ? instr_mem_q[rptr_q] : '0;
    instr_pc_out = valid ? pc_mem_q[rptr_q] : '0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit with a queue-based
// memory and prefetch model.
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_misalign_out;
  logic        instr_ready_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;

  fetch_unit #(
    .XLEN(32),
    .RESET_PC(RST_PC),
    .DEPTH(DEPTH)
  ) dut (
    .clkin(clk),
    .nrst_in(nrst),
    .imem_req_out(imem_req_out),
    .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in),
    .imem_rvalid_in(imem_rvalid_in),
    .imem_rdata_in(imem_rdata_in),
    .instr_valid_out(instr_valid_out),
    .instr_out(instr_out),
    .instr_pc_out(instr_pc_out),
    .instr_misalign_out(instr_misalign_out),
    .instr_ready_in(instr_ready_in),
    .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] pend_addr[$];
  bit          pend_stale[$];
  logic [31:0] fifo_pc[$];
  bit          fifo_mis[$];
  logic [31:0] exp_req_pc;
  bit          started;
  bit          halted;

  int          cyc;
  int          first_valid_cyc;
  int          grants;
  int          pops;
  logic [31:0] grant_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: drive at negedge, check, advance the model at posedge.
  task automatic run_cycle(input bit gnt, input bit rv, input bit rdy,
                           input bit redir, input logic [31:0] tgt);
    bit          rsp;
    bit          exp_req;
    bit          acc;
    bit          pop;
    bit          s;
    logic [31:0] a;
    logic [31:0] exp_instr;
    rsp = rv && (pend_addr.size() > 0);
    imem_gnt_in = gnt;
    imem_rvalid_in = rsp;
    imem_rdata_in = rsp ? memfn(pend_addr[0]) : $urandom;
    instr_ready_in = rdy;
    redirect_in = redir;
    redirect_pc_in = tgt;
    #1;
    exp_req = started && !halted &&
              (pend_addr.size() + fifo_pc.size() < DEPTH);
    checks++;
    if (imem_req_out !== exp_req) begin
      errors++;
      $display("FAIL req cyc=%0d: got %b expected %b", cyc, imem_req_out, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr_out !== exp_req_pc) begin
        errors++;
        $display("FAIL addr cyc=%0d: got %h expected %h", cyc, imem_addr_out, exp_req_pc);
      end
    end
    checks++;
    if (instr_valid_out !== (fifo_pc.size() > 0)) begin
      errors++;
      $display("FAIL valid cyc=%0d: got %b expected %b", cyc, instr_valid_out, fifo_pc.size() > 0);
    end
    if (fifo_pc.size() > 0) begin
      exp_instr = fifo_mis[0] ? 32'h0000_0013 : memfn(fifo_pc[0]);
      checks++;
      if (instr_pc_out !== fifo_pc[0]) begin
        errors++;
        $display("FAIL pc cyc=%0d: got %h expected %h", cyc, instr_pc_out, fifo_pc[0]);
      end
      checks++;
      if (instr_out !== exp_instr) begin
        errors++;
        $display("FAIL instr cyc=%0d: got %h expected %h", cyc, instr_out, exp_instr);
      end
      checks++;
      if (instr_misalign_out !== fifo_mis[0]) begin
        errors++;
        $display("FAIL misalign cyc=%0d: got %b expected %b", cyc, instr_misalign_out, fifo_mis[0]);
      end
    end
    if (instr_valid_out === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    acc = exp_req && gnt;
    pop = (fifo_pc.size() > 0) && rdy && !redir;
    if (pop) pop_log.push_back(instr_pc_out);
    if (acc) grant_log.push_back(imem_addr_out);
    @(posedge clk);
    if (pop) begin
      void'(fifo_pc.pop_front());
      void'(fifo_mis.pop_front());
      pops++;
    end
    if (rsp) begin
      a = pend_addr.pop_front();
      s = pend_stale.pop_front();
      if (!s && !redir) begin
        fifo_pc.push_back(a);
        fifo_mis.push_back(1'b0);
      end
    end
    if (acc) begin
      pend_addr.push_back(exp_req_pc);
      pend_stale.push_back(1'b0);
      exp_req_pc = exp_req_pc + 32'd4;
      grants++;
    end
    if (redir) begin
      fifo_pc.delete();
      fifo_mis.delete();
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
      halted = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_req_pc = tgt;
      if (tgt[1:0] != 2'b00) begin
        halted = 1'b1;
        fifo_pc.push_back(tgt);
        fifo_mis.push_back(1'b1);
      end
`else
      exp_req_pc = {tgt[31:2], 2'b00};
`endif
    end
    started = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    imem_gnt_in = 1'b0;
    imem_rvalid_in = 1'b0;
    instr_ready_in = 1'b0;
    redirect_in = 1'b0;
    #1;
    checks++;
    if (imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_req: got %b expected 0", imem_req_out);
    end
    checks++;
    if (imem_addr_out !== RST_PC) begin
      errors++;
      $display("FAIL rst_addr: got %h expected %h", imem_addr_out, RST_PC);
    end
    checks++;
    if (instr_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b expected 0", instr_valid_out);
    end
    checks++;
    if (instr_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_instr: got %h expected 0", instr_out);
    end
    checks++;
    if (instr_pc_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_pc: got %h expected 0", instr_pc_out);
    end
    checks++;
    if (instr_misalign_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_misalign: got %b expected 0", instr_misalign_out);
    end
    pend_addr.delete();
    pend_stale.delete();
    fifo_pc.delete();
    fifo_mis.delete();
    exp_req_pc = RST_PC;
    started = 1'b0;
    halted = 1'b0;
    cyc = 0;
    first_valid_cyc = -1;
    grants = 0;
    pops = 0;
    grant_log.delete();
    pop_log.delete();
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_stream();
    test_reset();
    for (int i = 0; i < 20; i++) run_cycle(1, 1, 1, 0, 0);
    checks++;
    if (first_valid_cyc != 3) begin
      errors++;
      $display("FAIL first_valid: got cycle %0d expected 3", first_valid_cyc);
    end
    checks++;
    if (pops != 17) begin
      errors++;
      $display("FAIL throughput: got %0d pops expected 17", pops);
    end
    checks++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 ||
        pop_log[2] !== 32'h8) begin
      errors++;
      $display("FAIL stream_pcs: got %0d entries expected 0,4,8", pop_log.size());
    end
  endtask

  task automatic test_ready_low();
    test_reset();
    for (int i = 0; i < 10; i++) run_cycle(1, 1, 0, 0, 0);
    checks++;
    if (grants != DEPTH) begin
      errors++;
      $display("FAIL stall_grants: got %0d expected %0d", grants, DEPTH);
    end
    checks++;
    if (imem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL stall_req: got %b expected 0", imem_req_out);
    end
    run_cycle(1, 1, 1, 0, 0);
    grants = 0;
    grant_log.delete();
    for (int i = 0; i < 4; i++) run_cycle(1, 1, 0, 0, 0);
    checks++;
    if (grants != 1 || grant_log.size() != 1 || grant_log[0] !== 32'h10) begin
      errors++;
      $display("FAIL credit_return: got %0d grants expected 1 at 00000010", grants);
    end
  endtask

  task automatic test_redirect_inflight();
    test_reset();
    for (int i = 0; i < 4; i++) run_cycle(1, 0, 1, 0, 0);
    checks++;
    if (grants != 3) begin
      errors++;
      $display("FAIL inflight_grants: got %0d expected 3", grants);
    end
    run_cycle(0, 0, 1, 1, 32'h100);
    pop_log.delete();
    for (int i = 0; i < 12; i++) run_cycle(1, 1, 1, 0, 0);
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL redirect_first: got %0d pops expected first pc 00000100", pop_log.size());
    end
  endtask

  task automatic test_redirect_same_cycle();
    int bad;
    test_reset();
    for (int i = 0; i < 6; i++) run_cycle(1, 1, 1, 0, 0);
    run_cycle(1, 1, 1, 1, 32'h200);
    pop_log.delete();
    for (int i = 0; i < 10; i++) run_cycle(1, 1, 1, 0, 0);
    bad = 0;
    foreach (pop_log[i]) if (pop_log[i] < 32'h200) bad++;
    checks++;
    if (bad != 0 || pop_log.size() == 0 || pop_log[0] !== 32'h200) begin
      errors++;
      $display("FAIL same_cycle: got %0d stale pops expected 0 and first pc 00000200", bad);
    end
  endtask

  task automatic test_wrap();
    run_cycle(1, 1, 1, 1, 32'hFFFF_FFFC);
    grant_log.delete();
    for (int i = 0; i < 6; i++) run_cycle(1, 1, 1, 0, 0);
    checks++;
    if (grant_log.size() < 2 || grant_log[0] !== 32'hFFFF_FFFC ||
        grant_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap: got %0d grants expected fffffffc then 00000000", grant_log.size());
    end
  endtask

  task automatic test_misalign();
    run_cycle(1, 1, 1, 1, 32'h102);
    grants = 0;
    grant_log.delete();
    pop_log.delete();
    for (int i = 0; i < 8; i++) run_cycle(1, 1, 1, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (grants != 0 || pop_log.size() != 1 || pop_log[0] !== 32'h102) begin
      errors++;
      $display("FAIL trap: got %0d grants %0d pops expected 0 grants one pop at 00000102", grants, pop_log.size());
    end
    run_cycle(1, 1, 1, 1, 32'h300);
    grant_log.delete();
    for (int i = 0; i < 4; i++) run_cycle(1, 1, 1, 0, 0);
    checks++;
    if (grant_log.size() == 0 || grant_log[0] !== 32'h300) begin
      errors++;
      $display("FAIL trap_resume: got %0d grants expected first at 00000300", grant_log.size());
    end
`else
    checks++;
    if (grant_log.size() == 0 || grant_log[0] !== 32'h100 ||
        pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL align_force: got %0d grants %0d pops expected first at 00000100", grant_log.size(), pop_log.size());
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] t;
    bit          rd;
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom_range(0, 15) == 0);
      t = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) t = t | 32'h2;
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) != 0, rd, t);
    end
    test_reset();
    for (int i = 0; i < 60; i++) begin
      run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 0, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_ready_low();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit for the RV32I core, the successor to the fixed single-cycle PC register and instruction-memory read path. It owns the program counter and issues pipelined requests to instruction memory over a request/grant/response handshake. Fetched words are buffered in a DEPTH-entry prefetch FIFO and presented to decode with a valid/ready handshake. On a branch or jump redirect it flushes the FIFO, discards stale in-flight responses and restarts fetch at the target.

## Interface
Parameters:
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2; also the outstanding-request limit.

Ports:
- clkin  input  1  system clock; all state changes on the rising edge.
- nrst_in  input  1  reset, asynchronous, active-low.
- imem_req_out  output  1  fetch request valid.
- imem_addr_out  output  XLEN  fetch byte address, word-aligned.
- imem_gnt_in  input  1  memory accepts the request this cycle.
- imem_rvalid_in  input  1  response valid; responses return in request order.
- imem_rdata_in  input  XLEN  instruction word.
- instr_valid_out  output  1  FIFO head valid.
- instr_out  output  XLEN  FIFO head instruction.
- instr_pc_out  output  XLEN  PC of the FIFO head.
- instr_misalign_out  output  1  head entry marks a misaligned redirect (see Configuration).
- instr_ready_in  input  1  decode consumes the head this cycle.
- redirect_in  input  1  branch/jump taken.
- redirect_pc_in  input  XLEN  redirect target.

## Operation
- State: fetch PC, FIFO (DEPTH entries holding instr and pc), in-flight counter, discard counter, FIFO count. Counter width is $clog2(DEPTH)+1.
- Request issue: imem_req_out = 1 when in-flight + FIFO count < DEPTH and the unit is not halted. imem_addr_out = fetch PC.
- Request hold: a request stays asserted with a stable address until granted.
- On grant: fetch PC += 4, wrapping modulo 2^XLEN; in-flight +1.
- On imem_rvalid_in:
  - in-flight −1.
  - If discard > 0: discard −1 and the data is dropped.
  - Otherwise the word is pushed with its PC. Entry PCs are tracked by a separate push-side PC counter.
- Pop: occurs when instr_valid_out && instr_ready_in.
- Push and pop in the same cycle: count unchanged. The credit rule guarantees a push never overflows.
- Redirect (redirect_in = 1), taking precedence over everything else:
  - FIFO emptied; any pop that cycle is ignored.
  - Fetch PC and push PC set to the target.
  - Discard counter set to the in-flight total after this cycle's grant and response are applied. A grant in the redirect cycle counts as stale; a response in the redirect cycle is dropped.
- Redirect while the discard counter is nonzero: the counter is recomputed as above, never accumulated.
- Reset mid-operation: all counters zero, FIFO empty, PC = RESET_PC. Responses to pre-reset requests are the memory's responsibility; memory is reset on the same nrst_in.

## Timing
- Reset values:
  - imem_req_out = 0, imem_addr_out = RESET_PC.
  - instr_valid_out = 0, instr_out = 0, instr_pc_out = 0, instr_misalign_out = 0.
- First request: imem_req_out rises in the first cycle after nrst_in deasserts.
- Response to output: a response in cycle N is visible on instr_valid_out in cycle N+1. Outputs are registered from FIFO storage.
- Throughput: one instruction per cycle with single-cycle grant and response.
- After a redirect in cycle N: the first request for the target is issued in cycle N+1. The FIFO is empty from N+1 until the first new response.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect target with bits[1:0] ≠ 0 halts fetch: no requests issue, and stale responses are still discarded.
  - One FIFO entry is pushed with instr = 32'h0000_0013 (NOP), pc = target, instr_misalign_out = 1.
  - Fetch stays halted until the next redirect.
- FETCH_MISALIGN_TRAP_EN undefined:
  - Target bits[1:0] are forced to 0 and fetch proceeds normally.
  - instr_misalign_out is constant 0.

## Test plan
- Reset, then memory grants every cycle with 1-cycle response, ready = 1 -> PCs 0x0, 0x4, 0x8… each one cycle apart; first instr_valid_out 3 cycles after reset release.
- Ready held low, DEPTH = 4 -> exactly 4 grants, then imem_req_out = 0. Releasing ready for one cycle -> one new request next cycle.
- 3 requests in flight, redirect to 0x100 -> the 3 old responses are dropped; first output has instr_pc_out = 0x100 with the matching data.
- Redirect asserted in the same cycle as a grant and a response -> both are stale; no output with the old PC appears.
- PC wrap: redirect to 0xFFFF_FFFC -> next request address 0x0000_0000.
- Redirect to 0x102:
  - with FETCH_MISALIGN_TRAP_EN: one entry with NOP, pc = 0x102, misalign = 1, then no requests until the next redirect.
  - without it: fetch from 0x100.
